// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the MAC-array sequencer and its PE grid.
// The MAC pipeline latency is shared with the PE so the drain window tracks the PE depth.
package tpu_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StDrain,
      StResult
   } seq_state_t;

   // Multiply register followed by accumulator register.
   localparam int unsigned MAC_PIPE_LAT = 2;

   function automatic int unsigned num_diags(input int unsigned rows, input int unsigned cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/mac_array_sequencer_if.sv
// Host command, operand request, PE grid control and result handshake bundle.
// The sequencer is the slave; the host, operand source and grid side use master.
interface mac_array_sequencer_if #(
   parameter int unsigned KW    = 16,
   parameter int unsigned DIAGS = 7
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [KW-1:0]    cmd_k;
   logic             op_valid;
   logic             op_ready;
   logic [KW-1:0]    op_idx;
   logic             op_last;
   logic             mac_clear;
   logic [DIAGS-1:0] mac_enable_diag;
   logic             res_valid;
   logic             res_ready;
   logic             busy;

   modport master (
      output cmd_valid, cmd_k, op_valid, res_ready,
      input  cmd_ready, op_ready, op_idx, op_last, mac_clear, mac_enable_diag, res_valid, busy
   );

   modport slave (
      input  cmd_valid, cmd_k, op_valid, res_ready,
      output cmd_ready, op_ready, op_idx, op_last, mac_clear, mac_enable_diag, res_valid, busy
   );

endinterface

// File: rtl/diag_enable_skew.sv
// Shift register that delays each operand fire by d+1 cycles onto anti-diagonal d,
// matching the operand wavefront through the skew registers of the grid.
module diag_enable_skew #(
   parameter int unsigned DEPTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fire,
   output logic [DEPTH-1:0] taps
);

   logic [DEPTH-1:0] stage;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage <= '0;
      end else begin
         stage <= (stage << 1) | DEPTH'(fire);
      end
   end

   assign taps = stage;

endmodule

// File: rtl/mac_array_sequencer.sv
// Sequences one output-stationary matmul pass: clear, operand feed with skewed
// per-diagonal enables, drain of the MAC pipeline, then hold result-valid.
module mac_array_sequencer
   import tpu_ctrl_pkg::*;
#(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 4,
   parameter int unsigned KW   = 16
) (
   input logic                  clk,
   input logic                  reset,
   mac_array_sequencer_if.slave bus
);

   localparam int unsigned DIAGS  = num_diags(ROWS, COLS);
   // Drain covers the last diagonal's skew plus the PE pipeline.
   localparam int unsigned DrainLd = DIAGS + MAC_PIPE_LAT - 1;
   localparam int unsigned DrainW  = $clog2(DrainLd + 1);

   seq_state_t        state;
   logic [KW-1:0]     k_q;
   logic [KW-1:0]     op_idx_q;
   logic [DrainW-1:0] drain_cnt;
   logic              clear_q;
   logic              fire;
   logic              idx_at_last;

   assign fire        = bus.op_valid && (state == StFeed);
   assign idx_at_last = (op_idx_q == (k_q - 1'b1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= StIdle;
         k_q       <= '0;
         op_idx_q  <= '0;
         drain_cnt <= '0;
         clear_q   <= 1'b0;
      end else begin
         clear_q <= 1'b0;
         unique case (state)
            StIdle: begin
               if (bus.cmd_valid) begin
                  k_q      <= bus.cmd_k;
                  op_idx_q <= '0;
                  clear_q  <= 1'b1;
                  state    <= StClear;
               end
            end
            StClear: begin
               // K=0 skips feed: the clear already leaves every accumulator at zero.
               state <= (k_q == '0) ? StResult : StFeed;
            end
            StFeed: begin
               if (fire) begin
                  op_idx_q <= op_idx_q + 1'b1;
                  if (idx_at_last) begin
                     drain_cnt <= DrainW'(DrainLd);
                     state     <= StDrain;
                  end
               end
            end
            StDrain: begin
               drain_cnt <= drain_cnt - 1'b1;
               if (drain_cnt == DrainW'(1)) begin
                  state <= StResult;
               end
            end
            StResult: begin
               if (bus.res_ready) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   diag_enable_skew #(
      .DEPTH (DIAGS)
   ) u_skew (
      .clk   (clk),
      .reset (reset),
      .fire  (fire),
      .taps  (bus.mac_enable_diag)
   );

   assign bus.cmd_ready = (state == StIdle);
   assign bus.op_ready  = (state == StFeed);
   assign bus.op_idx    = op_idx_q;
   assign bus.op_last   = (state == StFeed) && idx_at_last;
   assign bus.mac_clear = clear_q;
   assign bus.res_valid = (state == StResult);
   assign bus.busy      = (state != StIdle);

   a_clear_enable_excl: assert property (@(posedge clk) disable iff (!reset)
      !(bus.mac_clear && (|bus.mac_enable_diag)));

   a_idx_in_range: assert property (@(posedge clk) disable iff (!reset)
      (state == StFeed) |-> (op_idx_q < k_q));

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Self-checking bench: event-time reference for handshakes and diagonal enables,
// plus a behavioural 2-stage PE grid whose accumulators are compared to a plain matmul.
module tb_mac_array_sequencer;
   import tpu_ctrl_pkg::*;

   localparam int unsigned ROWS  = 4;
   localparam int unsigned COLS  = 4;
   localparam int unsigned KW    = 8;
   localparam int unsigned DIAGS = num_diags(ROWS, COLS);
   localparam int          MAXC  = 20000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mac_array_sequencer_if #(.KW(KW), .DIAGS(DIAGS)) bus ();

   mac_array_sequencer #(
      .ROWS (ROWS),
      .COLS (COLS),
      .KW   (KW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   bit     fire_hist [MAXC];
   int     fire_kx   [MAXC];
   int     a_m  [ROWS][256];
   int     b_m  [256][COLS];
   longint acc  [ROWS][COLS];
   longint prod [ROWS][COLS];
   bit     pv   [ROWS][COLS];

   int cmd_q [$];
   bit in_pass;
   int p_k, clear_t, res_start_t, fires, last_fire_t, oplast_fire_t;
   int last_hs_t, accept_gap, res_len;
   int mode, feed_idx, res_wait, res_cnt;
   bit early_rr;
   int pat [6] = '{1, 0, 1, 1, 0, 1};
   int obs_clear_t, obs_d0_t, obs_dl_t, obs_res_t;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
      chk({tag, "_op_ready"}, bus.op_ready, 0);
      chk({tag, "_op_last"}, bus.op_last, 0);
      chk({tag, "_mac_clear"}, bus.mac_clear, 0);
      chk({tag, "_enable"}, bus.mac_enable_diag, 0);
      chk({tag, "_res_valid"}, bus.res_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   task automatic start_pass(input int t);
      in_pass       = 1'b1;
      p_k           = int'(bus.cmd_k);
      clear_t       = t + 1;
      fires         = 0;
      last_fire_t   = -1;
      oplast_fire_t = -2;
      res_start_t   = (p_k == 0) ? t + 2 : -1;
      accept_gap    = t - last_hs_t;
      feed_idx      = 0;
      res_cnt       = 0;
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < 256; k++) a_m[r][k] = int'($urandom_range(0, 255));
      for (int k = 0; k < 256; k++)
         for (int c = 0; c < COLS; c++) b_m[k][c] = int'($urandom_range(0, 255));
      if (cmd_q.size() > 0) void'(cmd_q.pop_front());
   endtask

   task automatic finish_pass(input int t);
      longint gold;
      res_len   = res_cnt;
      last_hs_t = t;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            gold = 0;
            for (int k = 0; k < p_k; k++) gold += longint'(a_m[r][k]) * longint'(b_m[k][c]);
            chk($sformatf("acc_r%0dc%0d_k%0d", r, c, p_k), acc[r][c], gold);
         end
      end
      in_pass = 1'b0;
   endtask

   // PE(r,c) sees the slice fired d+1 cycles before its enable, d = r+c.
   task automatic grid_update(input int t, input bit clr, input logic [DIAGS-1:0] en);
      int d, src, kx;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            d   = r + c;
            src = t - 1 - d;
            if (clr) acc[r][c] = 0;
            else if (pv[r][c]) acc[r][c] += prod[r][c];
            pv[r][c] = en[d];
            if (src >= 0 && fire_hist[src]) begin
               kx = fire_kx[src] % 256;
               prod[r][c] = longint'(a_m[r][kx]) * longint'(b_m[kx][c]);
            end else begin
               prod[r][c] = 64'hDEAD;
            end
         end
      end
   endtask

   task automatic check_cycle();
      logic [DIAGS-1:0] exp_en;
      bit e_clr, e_rdy, e_res;
      int t;
      t      = cyc;
      exp_en = '0;
      for (int d = 0; d < int'(DIAGS); d++)
         if (t - 1 - d >= 0) exp_en[d] = fire_hist[t-1-d];
      e_clr = in_pass && (t == clear_t);
      e_rdy = in_pass && (p_k > 0) && (t > clear_t) && (fires < p_k);
      e_res = in_pass && (res_start_t >= 0) && (t >= res_start_t);
      chk("mac_enable_diag", bus.mac_enable_diag, exp_en);
      chk("mac_clear", bus.mac_clear, e_clr);
      chk("op_ready", bus.op_ready, e_rdy);
      chk("op_last", bus.op_last, e_rdy && (fires == p_k - 1));
      chk("res_valid", bus.res_valid, e_res);
      chk("cmd_ready", bus.cmd_ready, !in_pass);
      chk("busy", bus.busy, in_pass);
      if (e_clr || e_rdy) chk("op_idx", bus.op_idx, e_clr ? 0 : fires);
      if (bus.mac_clear === 1'b1) begin
         obs_clear_t = t;
         obs_d0_t    = -1;
         obs_dl_t    = -1;
         obs_res_t   = -1;
      end
      if (bus.mac_enable_diag[0] === 1'b1 && obs_d0_t < 0) obs_d0_t = t;
      if (bus.mac_enable_diag[DIAGS-1] === 1'b1 && obs_dl_t < 0) obs_dl_t = t;
      if (bus.res_valid === 1'b1 && obs_res_t < 0) obs_res_t = t;
   endtask

   task automatic drive();
      if (cmd_q.size() > 0) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_k     = KW'(cmd_q[0]);
      end else begin
         bus.cmd_valid = 1'b0;
         bus.cmd_k     = '0;
      end
      case (mode)
         0: bus.op_valid = 1'b1;
         1: begin
            bus.op_valid = bus.op_ready ? (pat[feed_idx % 6] != 0) : 1'b0;
            if (bus.op_ready) feed_idx++;
         end
         default: bus.op_valid = ($urandom_range(0, 1) == 1);
      endcase
      if (bus.res_valid) begin
         bus.res_ready = (res_cnt >= res_wait);
         res_cnt++;
      end else begin
         bus.res_ready = early_rr && ($urandom_range(0, 1) == 1);
      end
   endtask

   task automatic tick();
      int t;
      bit f, clr_c;
      logic [DIAGS-1:0] en_c;
      t = cyc;
      if (t >= MAXC - 1) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", t, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      f     = bus.op_valid && bus.op_ready;
      clr_c = bus.mac_clear;
      en_c  = bus.mac_enable_diag;
      fire_hist[t] = f;
      fire_kx[t]   = fires;
      if (in_pass && bus.res_valid && bus.res_ready) begin
         finish_pass(t);
      end else if (in_pass && f) begin
         if (bus.op_last) oplast_fire_t = t;
         fires++;
         if (fires == p_k) begin
            last_fire_t = t;
            res_start_t = t + int'(DIAGS) + 2;
         end
      end
      if (!in_pass && bus.cmd_valid && bus.cmd_ready) start_pass(t);
      @(posedge clk);
      grid_update(t, clr_c, en_c);
      #1;
      cyc++;
      check_cycle();
      drive();
   endtask

   task automatic run_cmds(input int budget);
      int b;
      b = 0;
      drive();
      while ((cmd_q.size() > 0 || in_pass) && b < budget) begin
         tick();
         b++;
      end
      chk("pass_in_budget", b < budget, 1);
   endtask

   task automatic model_reset();
      in_pass = 1'b0;
      cmd_q.delete();
      for (int i = cyc - 16; i <= cyc; i++)
         if (i >= 0) fire_hist[i] = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_k     = '0;
      bus.op_valid  = 1'b0;
      bus.res_ready = 1'b0;
      mode = 0; res_wait = 0; early_rr = 1'b0; in_pass = 1'b0;
      fires = 0; p_k = 0; clear_t = -10; res_start_t = -1; last_hs_t = -100;
      res_cnt = 0; feed_idx = 0; accept_gap = 0; res_len = 0;
      last_fire_t = -1; oplast_fire_t = -2;
      obs_clear_t = -1; obs_d0_t = -1; obs_dl_t = -1; obs_res_t = -1;
      for (int i = 0; i < MAXC; i++) begin
         fire_hist[i] = 1'b0;
         fire_kx[i]   = 0;
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            acc[r][c] = 0; prod[r][c] = 0; pv[r][c] = 1'b0;
         end

      #2 reset = 1'b0;
      #1;
      check_reset_outputs("por");
      repeat (3) tick();
      reset = 1'b1;
      repeat (2) tick();

      // K=3, operands always available
      mode = 0;
      cmd_q.push_back(3);
      run_cmds(200);
      chk("k3_diag0_lag", obs_d0_t - obs_clear_t, 2);
      chk("k3_diaglast_lag", obs_dl_t - obs_clear_t, 8);
      chk("k3_res_lag", obs_res_t - obs_clear_t, 12);

      // K=4 with bubbles 1,0,1,1,0,1
      mode = 1;
      cmd_q.push_back(4);
      run_cmds(200);
      chk("k4_fires", fires, 4);
      chk("k4_last_fire_lag", last_fire_t - clear_t, 6);
      chk("k4_op_last_on_4th", oplast_fire_t, last_fire_t);

      // K=0
      mode = 0;
      cmd_q.push_back(0);
      run_cmds(50);
      chk("k0_res_lag", obs_res_t - obs_clear_t, 1);

      // Slow consumer, back-to-back with cmd_valid held
      res_wait = 5;
      cmd_q.push_back(2);
      cmd_q.push_back(5);
      run_cmds(300);
      chk("slow_res_len", res_len, 6);
      chk("b2b_accept_gap", accept_gap, 1);
      res_wait = 0;

      // Randomized passes with bubbles, early res_ready and back-to-back commands
      for (int i = 0; i < 30; i++) begin
         mode     = 2;
         early_rr = 1'b1;
         res_wait = int'($urandom_range(0, 3));
         cmd_q.push_back(int'($urandom_range(0, 12)));
         if ($urandom_range(0, 2) == 0) cmd_q.push_back(int'($urandom_range(0, 12)));
         run_cmds(3000);
      end
      early_rr = 1'b0;
      res_wait = 0;

      // Largest K: op_idx must run to the top without wrapping early
      mode = 0;
      cmd_q.push_back((1 << KW) - 1);
      run_cmds(1000);
      chk("kmax_fires", fires, (1 << KW) - 1);

      // Reset asserted mid-feed with K=8
      mode = 0;
      cmd_q.push_back(8);
      drive();
      begin
         int b;
         b = 0;
         while (fires < 3 && b < 50) begin
            tick();
            b++;
         end
         chk("reach_feed", b < 50, 1);
      end
      reset = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midrst");
      drive();
      repeat (4) tick();
      reset = 1'b1;
      tick();
      chk("post_rst_cmd_ready", bus.cmd_ready, 1);
      cmd_q.push_back(1);
      run_cmds(100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
